// File: rtl/abacus_pkg.sv
// Register map constants and decode selectors for the abacus event counter bank.
package abacus_pkg;

    localparam logic [31:0] OFF_CTRL    = 32'h000;
    localparam logic [31:0] OFF_CHAN_EN = 32'h004;
    localparam logic [31:0] OFF_OVF     = 32'h008;
    localparam logic [31:0] OFF_INFO    = 32'h00C;
    localparam logic [31:0] CNT_BASE    = 32'h100;
    localparam int          CNT_STRIDE  = 8;
    localparam int          CNT_SHIFT   = $clog2(CNT_STRIDE);

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_CTRL,
        REG_CHAN_EN,
        REG_OVF,
        REG_INFO,
        REG_CNT_LO,
        REG_CNT_HI
    } reg_sel_e;

endpackage

// File: rtl/abacus_counter_cell.sv
// One event counter: increments on inc, clears on clr, wraps or saturates at all-ones.
module abacus_counter_cell #(
    parameter int COUNTER_WIDTH = 48,
    parameter bit SATURATE      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc,
    input  logic                     clr,
    output logic [COUNTER_WIDTH-1:0] cnt,
    output logic                     ovf
);

    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_nxt;
    logic                     at_max;

    assign at_max = &cnt_q;
    // A clear in the same cycle discards the increment, so no overflow is reported.
    assign ovf    = inc & at_max & ~clr;
    assign cnt    = cnt_q;

    always_comb begin
        cnt_nxt = cnt_q;
        if (clr) begin
            cnt_nxt = '0;
        end else if (inc && !(at_max && SATURATE)) begin
            cnt_nxt = cnt_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: rtl/abacus_counter_bank.sv
// Bank of event counters behind a Wishbone register window with a shared high-word latch.
module abacus_counter_bank
    import abacus_pkg::*;
#(
    parameter logic [31:0] ABACUS_BASE_ADDR = 32'hf0030000,
    parameter int          NUM_COUNTERS     = 8,
    parameter int          COUNTER_WIDTH    = 48,
    parameter bit          SATURATE         = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_COUNTERS-1:0] event_i,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [31:0]             wb_adr,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack,
    output logic                    ovf_irq_o
);

    localparam logic [7:0] INFO_CW = 8'(COUNTER_WIDTH);
    localparam logic [7:0] INFO_NC = 8'(NUM_COUNTERS);

    logic                     ctrl_en_q;
    logic [NUM_COUNTERS-1:0]  chan_en_q;
    logic [NUM_COUNTERS-1:0]  ovf_q;
    logic [31:0]              hi_latch_q;

    logic [COUNTER_WIDTH-1:0] cnt [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  inc;
    logic [NUM_COUNTERS-1:0]  clr;
    logic [NUM_COUNTERS-1:0]  ovf_set;
    logic [NUM_COUNTERS-1:0]  ovf_w1c;

    logic [31:0]              off;
    logic [31:0]              off_w;
    logic [31:0]              rel;
    logic [31:0]              cnt_idx;
    reg_sel_e                 sel;
    logic [63:0]              cnt_ext;
    logic [31:0]              rdata;

    logic                     bus_req;
    logic                     wr_commit;
    logic                     clear_all;
    logic                     cnt_wr;
    logic                     unused_bits;

    // Reads are sampled on the edge that raises ack; writes commit on the edge that ends it.
    assign bus_req   = wb_cyc & wb_stb & ~wb_ack;
    assign wr_commit = wb_cyc & wb_stb & wb_we & wb_ack;
    assign clear_all = wr_commit && (sel == REG_CTRL) && wb_dat_i[CTRL_CLR_BIT];
    assign cnt_wr    = wr_commit && (sel == REG_CNT_LO);
    assign ovf_w1c   = (wr_commit && (sel == REG_OVF)) ? wb_dat_i[NUM_COUNTERS-1:0] : '0;
    assign ovf_irq_o = |(ovf_q & chan_en_q);
    assign unused_bits = ^{wb_dat_i, off[1:0], rel[1:0]};

    always_comb begin
        off     = wb_adr - ABACUS_BASE_ADDR;
        off_w   = {off[31:2], 2'b00};
        rel     = off_w - CNT_BASE;
        cnt_idx = rel >> CNT_SHIFT;
        sel     = REG_NONE;
        case (off_w)
            OFF_CTRL:    sel = REG_CTRL;
            OFF_CHAN_EN: sel = REG_CHAN_EN;
            OFF_OVF:     sel = REG_OVF;
            OFF_INFO:    sel = REG_INFO;
            default: begin
                if ((off_w >= CNT_BASE) && (cnt_idx < 32'(NUM_COUNTERS))) begin
                    sel = rel[2] ? REG_CNT_HI : REG_CNT_LO;
                end
            end
        endcase
    end

    always_comb begin
        cnt_ext = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (cnt_idx == 32'(i)) begin
                cnt_ext = 64'(cnt[i]);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:    rdata = {31'b0, ctrl_en_q};
            REG_CHAN_EN: rdata = 32'(chan_en_q);
            REG_OVF:     rdata = 32'(ovf_q);
            REG_INFO:    rdata = {16'h0, INFO_CW, INFO_NC};
            REG_CNT_LO:  rdata = cnt_ext[31:0];
            REG_CNT_HI:  rdata = hi_latch_q;
            default:     rdata = '0;
        endcase
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_cell
        assign inc[g] = event_i[g] & chan_en_q[g] & ctrl_en_q;
        assign clr[g] = clear_all | (cnt_wr && (cnt_idx == 32'(g)));

        abacus_counter_cell #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .SATURATE      (SATURATE)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[g]),
            .clr   (clr[g]),
            .cnt   (cnt[g]),
            .ovf   (ovf_set[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack     <= 1'b0;
            wb_dat_o   <= '0;
            ctrl_en_q  <= 1'b0;
            chan_en_q  <= '0;
            ovf_q      <= '0;
            hi_latch_q <= '0;
        end else begin
            wb_ack   <= bus_req;
            wb_dat_o <= (bus_req && !wb_we) ? rdata : '0;
            // High word is captured with the low word so a split 64-bit read is coherent.
            if (bus_req && !wb_we && (sel == REG_CNT_LO)) begin
                hi_latch_q <= cnt_ext[63:32];
            end
            if (wr_commit && (sel == REG_CTRL)) begin
                ctrl_en_q <= wb_dat_i[CTRL_EN_BIT];
            end
            if (wr_commit && (sel == REG_CHAN_EN)) begin
                chan_en_q <= wb_dat_i[NUM_COUNTERS-1:0];
            end
            ovf_q <= (ovf_q & ~ovf_w1c) | ovf_set;
        end
    end

endmodule

// File: tb/tb_abacus_counter_bank.sv
// Three counter banks (48-bit wrap, 8-bit wrap, 8-bit saturate) sharing one bus and event source.
module tb_abacus_counter_bank;
    import abacus_pkg::*;

    localparam logic [31:0] BASE = 32'hf0030000;

    typedef struct {
        string       name;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] off;
        logic [31:0] dat;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ec;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  events;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] dat_a, dat_b, dat_c;
    logic        ack_a, ack_b, ack_c;
    logic        irq_a, irq_b, irq_c;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t tbl[$];

    abacus_counter_bank #(.ABACUS_BASE_ADDR(BASE), .NUM_COUNTERS(8), .COUNTER_WIDTH(48), .SATURATE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .event_i(events), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat_a), .wb_ack(ack_a), .ovf_irq_o(irq_a));

    abacus_counter_bank #(.ABACUS_BASE_ADDR(BASE), .NUM_COUNTERS(8), .COUNTER_WIDTH(8), .SATURATE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .event_i(events), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat_b), .wb_ack(ack_b), .ovf_irq_o(irq_b));

    abacus_counter_bank #(.ABACUS_BASE_ADDR(BASE), .NUM_COUNTERS(8), .COUNTER_WIDTH(8), .SATURATE(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .event_i(events), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat_c), .wb_ack(ack_c), .ovf_irq_o(irq_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got time %0t required < 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    // Read responses are matched in order against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ack_a && !wb_we) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read_ack: got ack with data 0x%08h required no ack", dat_a);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "/w48"}, dat_a, mon_e.ea);
                chk({mon_e.name, "/w8wrap"}, dat_b, mon_e.eb);
                chk({mon_e.name, "/w8sat"}, dat_c, mon_e.ec);
            end
        end
    end

    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        int n;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack_a && n < 8);
        if (!ack_a) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got no ack after %0d cycles at adr 0x%08h required ack", n, adr);
        end
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, input logic [31:0] ea, input logic [31:0] eb,
                      input logic [31:0] ec, input string nm);
        exp_t e;
        e.name = nm; e.ea = ea; e.eb = eb; e.ec = ec;
        sb_q.push_back(e);
        bus_xfer(1'b0, BASE + off, 32'h0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] dat);
        bus_xfer(1'b1, BASE + off, dat);
    endtask

    task automatic pulse(input logic [7:0] m, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            events = m;
        end
        @(negedge clk);
        events = '0;
    endtask

    task automatic add_vec(input logic we, input logic [31:0] off, input logic [31:0] dat,
                           input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                           input string nm);
        vec_t v;
        v.we = we; v.off = off; v.dat = dat; v.ea = ea; v.eb = eb; v.ec = ec; v.name = nm;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] lo(input int i);
        return CNT_BASE + 32'(8 * i);
    endfunction

    initial begin
        rst_n = 1'b0; events = '0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_ack_a", 32'(ack_a), 0); chk("rst_ack_b", 32'(ack_b), 0); chk("rst_ack_c", 32'(ack_c), 0);
        chk("rst_dat_a", dat_a, 0);      chk("rst_dat_b", dat_b, 0);      chk("rst_dat_c", dat_c, 0);
        chk("rst_irq_a", 32'(irq_a), 0); chk("rst_irq_b", 32'(irq_b), 0); chk("rst_irq_c", 32'(irq_c), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        add_vec(0, OFF_CTRL,     0, 0, 0, 0, "ctrl_after_reset");
        add_vec(0, OFF_CHAN_EN,  0, 0, 0, 0, "chan_en_after_reset");
        add_vec(0, OFF_OVF,      0, 0, 0, 0, "ovf_after_reset");
        add_vec(0, OFF_INFO,     0, 32'h0000_3008, 32'h0000_0808, 32'h0000_0808, "info");
        add_vec(0, lo(0),        0, 0, 0, 0, "cnt0_after_reset");
        add_vec(1, OFF_CTRL,     32'h1, 0, 0, 0, "wr_ctrl");
        add_vec(1, OFF_CHAN_EN,  32'h1, 0, 0, 0, "wr_chan_en");
        add_vec(0, OFF_CTRL,     0, 1, 1, 1, "ctrl_readback");
        add_vec(0, OFF_CHAN_EN,  0, 1, 1, 1, "chan_en_readback");
        add_vec(0, 32'h010,      0, 0, 0, 0, "unmapped_read");
        add_vec(1, 32'h010,      32'hffff_ffff, 0, 0, 0, "unmapped_write");
        add_vec(0, lo(8),        0, 0, 0, 0, "out_of_range_channel");
        add_vec(0, 32'hffff_fffc, 0, 0, 0, 0, "below_base");
        add_vec(0, 32'h003,      0, 1, 1, 1, "ctrl_low_bits_ignored");
        add_vec(0, OFF_INFO,     0, 32'h0000_3008, 32'h0000_0808, 32'h0000_0808, "info_after_writes");
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].we) wr(tbl[i].off, tbl[i].dat);
            else rd(tbl[i].off, tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].name);
        end

        pulse(8'h01, 10);
        rd(lo(0), 10, 10, 10, "ten_events");
        rd(lo(0) + 4, 0, 0, 0, "ten_events_hi");
        rd(lo(1), 0, 0, 0, "idle_cnt1");
        rd(lo(7), 0, 0, 0, "idle_cnt7");

        fork
            pulse(8'h01, 6);
            rd(lo(1), 0, 0, 0, "read_during_events");
        join
        rd(lo(0), 16, 16, 16, "no_events_dropped");

        wr(lo(0), 32'hdead_beef);
        @(negedge clk);
        force dut_a.g_cell[0].u_cell.cnt_q = 48'h0000_ffff_ffff;
        @(negedge clk);
        release dut_a.g_cell[0].u_cell.cnt_q;
        pulse(8'h01, 1);
        rd(lo(0), 0, 1, 1, "carry_lo");
        rd(lo(5) + 4, 1, 0, 0, "carry_hi_any_index");
        rd(OFF_OVF, 0, 0, 0, "carry_no_ovf");

        wr(lo(0), 32'h0);
        pulse(8'h01, 256);
        rd(lo(0), 256, 0, 32'hff, "wrap_vs_saturate");
        rd(OFF_OVF, 0, 1, 1, "ovf_after_256");
        chk("irq_after_256_w48", 32'(irq_a), 0);
        chk("irq_after_256_w8wrap", 32'(irq_b), 1);
        chk("irq_after_256_w8sat", 32'(irq_c), 1);

        wr(OFF_CHAN_EN, 32'h0d);
        pulse(8'h04, 3);
        rd(lo(2), 3, 3, 3, "cnt2_before_clear");
        fork
            wr(OFF_CTRL, 32'h3);
            pulse(8'h04, 2);
        join
        rd(lo(2), 0, 0, 0, "clear_wins_cnt2");
        rd(lo(0), 0, 0, 0, "clear_all_cnt0");
        rd(OFF_CTRL, 1, 1, 1, "clear_bit_self_clears");
        rd(OFF_OVF, 0, 1, 1, "clear_keeps_ovf");
        pulse(8'h04, 1);
        rd(lo(2), 1, 1, 1, "count_after_clear");

        pulse(8'h08, 256);
        pulse(8'h08, 255);
        fork
            wr(OFF_OVF, 32'h08);
            begin
                @(negedge clk);
                pulse(8'h08, 1);
            end
        join
        rd(OFF_OVF, 0, 32'h09, 32'h09, "ovf_set_wins");
        rd(lo(3), 512, 0, 32'hff, "cnt3_after_overflow");
        wr(OFF_OVF, 32'h09);
        rd(OFF_OVF, 0, 0, 0, "ovf_w1c_clears");
        chk("irq_cleared_w8wrap", 32'(irq_b), 0);
        chk("irq_cleared_w8sat", 32'(irq_c), 0);

        @(negedge clk);
        force dut_a.g_cell[0].u_cell.cnt_q = 48'h0000_ffff_ffff;
        @(negedge clk);
        release dut_a.g_cell[0].u_cell.cnt_q;
        fork
            rd(lo(0), 32'hffff_ffff, 0, 0, "read_pre_increment");
            pulse(8'h01, 1);
        join
        rd(lo(0) + 4, 0, 0, 0, "hi_consistent_with_lo");
        rd(lo(0), 0, 1, 1, "read_post_increment");
        rd(lo(3) + 4, 1, 0, 0, "hi_after_post_read");

        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = BASE + lo(2); wb_dat_i = '0;
        #1 rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_ack_w48", 32'(ack_a), 0);
            chk("abort_ack_w8wrap", 32'(ack_b), 0);
            chk("abort_dat_w48", dat_a, 0);
        end
        chk("abort_irq", 32'(irq_a | irq_b | irq_c), 0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rd(lo(0) + 4, 0, 0, 0, "hi_latch_after_abort");
        rd(OFF_CTRL, 0, 0, 0, "ctrl_after_abort");
        rd(OFF_CHAN_EN, 0, 0, 0, "chan_en_after_abort");
        rd(lo(2), 0, 0, 0, "cnt2_after_abort");
        rd(lo(3), 0, 0, 0, "cnt3_after_abort");
        pulse(8'h0f, 2);
        rd(lo(3), 0, 0, 0, "disabled_after_abort");

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
